seven_seg_frame_decoder: RTL and testbench
==========================================

Name: seven_seg_frame_decoder

Overview:
Receive-side counterpart of the team's hex-to-seven-segment driver. It observes a multiplexed common-anode display bus (active-low segments, active-low digit strobes) and recovers each digit's 4-bit hex value, dot state, blank state and error state. A complete snapshot of all digits is presented as one frame on a valid/ready output. It sits on the display-loopback and self-test path, where it checks what the display driver actually emits.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits and width of an_n.
STABLE_CYCLES, 8, consecutive identical samples (range 2..255) required before a digit is committed.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
seg_n  input  7  segment lines, active-low; bit0=a, bit1=b, ..., bit6=g
dp_n  input  1  decimal-point line, active-low
an_n  input  NUM_DIGITS  digit strobes, active-low; bit i selects digit i
out_valid  output  1  frame available
out_ready  input  1  consumer accepts frame
out_digits  output  4*NUM_DIGITS  hex value of digit i at bits [4i+3:4i]
out_dp  output  NUM_DIGITS  1 = dot lit on digit i
out_blank  output  NUM_DIGITS  1 = digit i fully dark (seg_n = 7'h7F)
out_err  output  NUM_DIGITS  1 = digit i carried an unrecognised glyph
overrun  output  1  sticky: a completed frame was dropped

Behaviour:
- Reset (sync, active-high) clears all outputs, input registers, the stability counter, the per-digit committed flags and the scratch frame to 0. It applies mid-frame with no partial output.
- Inputs pass through 2 register stages before use. Decode latency is measured from the registered copy.
- Strobe decode: exactly one an_n bit low gives active index idx. All-high or more than one low means idle: no sample is taken, the stability counter clears and the commit is re-armed.
- Stability: {seg_n, dp_n, idx} compared with the previous cycle. On any change, the counter is reloaded to 1 and the commit is re-armed. When unchanged, the counter increments and saturates at STABLE_CYCLES.
- Commit: fires on the cycle the counter reaches STABLE_CYCLES while armed, and only once per armed window; it then disarms.
- On commit, the scratch frame slot idx gets the value, dp = ~dp_n, blank and err, and committed[idx] is set.
- Glyph table (seg_n hex -> value): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F.
- 7F: value 0, blank=1, err=0.
- Any other pattern: value 0, blank=0, err=1.
- Frame complete: the cycle after all committed bits are 1.
  - If out_valid=0, or out_valid & out_ready in that cycle: load the output registers from scratch, out_valid=1, clear all committed bits.
  - Else (out_valid & ~out_ready): outputs hold unchanged, the frame is dropped, committed bits clear, overrun sets to 1 and stays 1 until reset.
- Handshake: out_valid & out_ready with no frame completion gives out_valid=0 next cycle; outputs hold their values. Outputs never change while out_valid=1 and out_ready=0.
- A digit committed twice before the frame completes: the later commit overwrites its scratch slot.
- Counter width is ceil(log2(STABLE_CYCLES+1)) bits, unsigned, and it never wraps.

Test Plan:
- Reset then a clean scan, out_ready=1, digits 0..3 showing 1,2,3,4 (seg_n 79,24,30,19), 12 cycles per strobe, dp_n=1 -> one frame with out_digits=16'h4321, out_dp=0, out_blank=0, out_err=0, out_valid for 1 cycle.
- Glitch: digit 2 holds 5 cycles, flips seg_n for 1 cycle, then returns for 8 cycles -> exactly one commit, at the 8th stable cycle after the glitch; frame correct.
- Blank and error: digit 0 = 7F, digit 1 = 7E, digit 3 dp_n=0 -> out_blank=4'b0001, out_err=4'b0010, out_dp=4'b1000, digit 0 and digit 1 values = 0.
- Backpressure: out_ready=0 across two complete frames -> first frame held bit-exact, second dropped, overrun=1. Then out_ready=1 -> out_valid drops the next cycle and overrun stays 1.
- Strobe faults: an_n=4'b0011 for 20 cycles, then all-high -> no commits, out_valid stays 0.
- Reset mid-scan after 3 digits committed -> all outputs 0; a full new scan is required before out_valid rises.

Source files
------------

// File: rtl/seven_seg_frame_decoder.sv
// Seven-segment bus observer: recovers per-digit hex/dot/blank/error
// from a multiplexed common-anode display and emits whole frames.
module seven_seg_frame_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_n,
  input  logic                    dp_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_dp,
  output logic [NUM_DIGITS-1:0]   out_blank,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    overrun
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(STABLE_CYCLES);

  logic [6:0]              r_seg_q1, r_seg_q2;
  logic                    r_dp_q1, r_dp_q2;
  logic [NUM_DIGITS-1:0]   r_an_q1, r_an_q2;

  logic [6:0]              r_prev_seg;
  logic                    r_prev_dp;
  logic [IW-1:0]           r_prev_idx;
  logic [CW-1:0]           r_cnt;
  logic                    r_armed;

  logic [4*NUM_DIGITS-1:0] r_scr_digits;
  logic [NUM_DIGITS-1:0]   r_scr_dp;
  logic [NUM_DIGITS-1:0]   r_scr_blank;
  logic [NUM_DIGITS-1:0]   r_scr_err;
  logic [NUM_DIGITS-1:0]   r_committed;

  logic                    r_out_valid;
  logic [4*NUM_DIGITS-1:0] r_out_digits;
  logic [NUM_DIGITS-1:0]   r_out_dp;
  logic [NUM_DIGITS-1:0]   r_out_blank;
  logic [NUM_DIGITS-1:0]   r_out_err;
  logic                    r_overrun;

  logic                    w_one_hot;
  logic [IW-1:0]           w_idx;
  logic [3:0]              w_val;
  logic                    w_blank;
  logic                    w_err;
  logic                    w_match;
  logic [CW-1:0]           w_cnt_nxt;
  logic                    w_commit;
  logic [NUM_DIGITS-1:0]   w_cmask;
  logic                    w_done;
  logic                    w_accept;

  // Two-flop synchroniser on the asynchronous display bus
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg_q1 <= '0;
      r_seg_q2 <= '0;
      r_dp_q1  <= 1'b0;
      r_dp_q2  <= 1'b0;
      r_an_q1  <= '0;
      r_an_q2  <= '0;
    end else begin
      r_seg_q1 <= seg_n;
      r_seg_q2 <= r_seg_q1;
      r_dp_q1  <= dp_n;
      r_dp_q2  <= r_dp_q1;
      r_an_q1  <= an_n;
      r_an_q2  <= r_an_q1;
    end
  end

  // Strobe decode: a sample is valid only with exactly one strobe low
  always_comb begin
    w_idx     = '0;
    w_one_hot = ($countones(~r_an_q2) == 1);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!r_an_q2[i]) w_idx = IW'(i);
    end
  end

  // Glyph lookup of the synchronised segment pattern
  always_comb begin
    w_val   = 4'h0;
    w_blank = 1'b0;
    w_err   = 1'b0;
    case (r_seg_q2)
      7'h40: w_val = 4'h0;
      7'h79: w_val = 4'h1;
      7'h24: w_val = 4'h2;
      7'h30: w_val = 4'h3;
      7'h19: w_val = 4'h4;
      7'h12: w_val = 4'h5;
      7'h02: w_val = 4'h6;
      7'h78: w_val = 4'h7;
      7'h00: w_val = 4'h8;
      7'h10: w_val = 4'h9;
      7'h08: w_val = 4'hA;
      7'h03: w_val = 4'hB;
      7'h46: w_val = 4'hC;
      7'h21: w_val = 4'hD;
      7'h06: w_val = 4'hE;
      7'h0E: w_val = 4'hF;
      7'h7F: w_blank = 1'b1;
      default: w_err = 1'b1;
    endcase
  end

  // Run-length of identical samples; a zero count means no prior sample
  always_comb begin
    w_match = (r_cnt != '0)
           && (r_seg_q2 == r_prev_seg)
           && (r_dp_q2 == r_prev_dp)
           && (w_idx == r_prev_idx);
    w_cnt_nxt = r_cnt;
    if (!w_one_hot) begin
      w_cnt_nxt = '0;
    end else if (!w_match) begin
      w_cnt_nxt = CW'(1);
    end else if (r_cnt != C_MAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
    w_commit = w_one_hot && w_match && r_armed
            && (w_cnt_nxt == C_MAX);
    w_cmask = '0;
    if (w_commit) w_cmask[w_idx] = 1'b1;
  end

  // Stability tracker: counter, last sample and one-shot arm flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_prev_seg <= '0;
      r_prev_dp  <= 1'b0;
      r_prev_idx <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (!w_one_hot || !w_match) begin
        r_armed <= 1'b1;
      end else if (w_commit) begin
        r_armed <= 1'b0;
      end
      if (w_one_hot) begin
        r_prev_seg <= r_seg_q2;
        r_prev_dp  <= r_dp_q2;
        r_prev_idx <= w_idx;
      end
    end
  end

  // Scratch frame: a later commit of the same digit overwrites it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scr_digits <= '0;
      r_scr_dp     <= '0;
      r_scr_blank  <= '0;
      r_scr_err    <= '0;
    end else if (w_commit) begin
      r_scr_digits[{w_idx, 2'b00} +: 4] <= w_val;
      r_scr_dp[w_idx]    <= ~r_dp_q2;
      r_scr_blank[w_idx] <= w_blank;
      r_scr_err[w_idx]   <= w_err;
    end
  end

  assign w_done   = &r_committed;
  assign w_accept = !r_out_valid || out_ready;

  // Committed flags: cleared by a completed frame, set by new commits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_committed <= '0;
    end else begin
      r_committed <= (w_done ? '0 : r_committed) | w_cmask;
    end
  end

  // Output frame register with valid/ready and sticky overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_digits <= '0;
      r_out_dp     <= '0;
      r_out_blank  <= '0;
      r_out_err    <= '0;
      r_overrun    <= 1'b0;
    end else if (w_done && w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_digits <= r_scr_digits;
      r_out_dp     <= r_scr_dp;
      r_out_blank  <= r_scr_blank;
      r_out_err    <= r_scr_err;
    end else if (w_done) begin
      r_overrun <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_digits = r_out_digits;
  assign out_dp     = r_out_dp;
  assign out_blank  = r_out_blank;
  assign out_err    = r_out_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_seven_seg_frame_decoder.sv
// Bench for seven_seg_frame_decoder: frame-level model plus
// directed scans with literal expectations.
module tb_seven_seg_frame_decoder;

  localparam int ND = 4;
  localparam int SC = 8;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_digits;
  logic [3:0]  out_dp;
  logic [3:0]  out_blank;
  logic [3:0]  out_err;
  logic        overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_loads = 0;
  int rise_cyc = 0;

  seven_seg_frame_decoder #(
    .NUM_DIGITS(ND),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg_n(seg_n),
    .dp_n(dp_n),
    .an_n(an_n),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_digits(out_digits),
    .out_dp(out_dp),
    .out_blank(out_blank),
    .out_err(out_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {err, blank, value} of a segment pattern from the glyph table
  function automatic logic [5:0] glyph(input logic [6:0] s);
    for (int j = 0; j < 16; j++) begin
      if (GLYPH[j] == s) return {2'b00, 4'(j)};
    end
    if (s == 7'h7F) return 6'b010000;
    return 6'b100000;
  endfunction

  // Model: run-length of identical strobed samples, frame assembly
  frame_t      exp_q[$];
  frame_t      m_scr;
  logic [11:0] m_key;
  int          m_run;
  logic [3:0]  m_comm;
  bit          m_valid;
  bit          m_ovr;

  always @(posedge clk) begin
    logic [5:0] g;
    int idx;
    if (reset) begin
      exp_q.delete();
      m_scr = '0; m_key = '0; m_run = 0;
      m_comm = '0; m_valid = 0; m_ovr = 0;
    end else begin
      if (m_valid && out_ready) m_valid = 0;
      if ($countones(~an_n) != 1) begin
        m_run = 0;
      end else begin
        if (m_run > 0 && {an_n, seg_n, dp_n} == m_key) m_run++;
        else m_run = 1;
        m_key = {an_n, seg_n, dp_n};
        if (m_run == SC) begin
          idx = 0;
          for (int i = 0; i < ND; i++) if (!an_n[i]) idx = i;
          g = glyph(seg_n);
          m_scr.dig[4*idx +: 4] = g[3:0];
          m_scr.dp[idx]    = ~dp_n;
          m_scr.blank[idx] = g[4];
          m_scr.err[idx]   = g[5];
          m_comm[idx] = 1'b1;
          if (&m_comm) begin
            if (!m_valid) begin
              exp_q.push_back(m_scr);
              m_valid = 1;
            end else begin
              m_ovr = 1;
            end
            m_comm = '0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of the DUT outputs against the model
  logic   p_valid, p_ready;
  frame_t p_frm;

  always @(negedge clk) begin
    frame_t cur;
    frame_t f;
    cur = {out_digits, out_dp, out_blank, out_err};
    if (reset) begin
      p_valid = 0; p_ready = 0; p_frm = '0;
    end else begin
      if (p_valid && !p_ready)
        chk("hold", 64'({out_valid, cur}), 64'({1'b1, p_frm}));
      if (out_valid && (!p_valid || p_ready)) begin
        rise_cyc = cyc;
        n_loads++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_frame: got %0h expected none", cur);
        end else begin
          f = exp_q.pop_front();
          chk("frame", 64'(cur), 64'(f));
        end
      end
      chk("overrun_early", 64'(overrun & ~m_ovr), 64'(0));
      p_valid = out_valid;
      p_ready = out_ready;
      p_frm   = cur;
    end
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] s,
                       input logic d, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      an_n = an; seg_n = s; dp_n = d;
    end
  endtask

  task automatic idle(input int n);
    drive(4'hF, 7'h7F, 1'b1, n);
  endtask

  task automatic scan(input logic [27:0] segs, input logic [3:0] dpn,
                      input logic [3:0] mask);
    for (int d = 0; d < ND; d++) begin
      if (mask[d]) drive(~(4'(1) << d), segs[7*d +: 7], dpn[d], 12);
    end
  endtask

  task automatic check_outs(input string name, input frame_t e);
    chk(name, 64'({out_digits, out_dp, out_blank, out_err}), 64'(e));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int l0;
    reset = 1'b1; out_ready = 1'b1;
    an_n = 4'hF; seg_n = 7'h7F; dp_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_state", 64'({out_valid, out_digits, out_dp,
        out_blank, out_err, overrun}), 64'(0));

    // Clean scan 1,2,3,4
    idle(2);
    l0 = n_loads;
    t0 = cyc + 1;
    scan({7'h19, 7'h30, 7'h24, 7'h79}, 4'hF, 4'hF);
    idle(8);
    chk("t1_latency", 64'(rise_cyc - t0), 64'(47));
    check_outs("t1_frame", {16'h4321, 4'h0, 4'h0, 4'h0});
    chk("t1_valid_pulse", 64'(out_valid), 64'(0));
    chk("t1_loads", 64'(n_loads - l0), 64'(1));

    // Glitch on the last-scanned digit
    l0 = n_loads;
    scan({7'h00, 7'h78, 7'h02, 7'h12}, 4'hF, 4'b1011);
    drive(4'b1011, 7'h78, 1'b1, 5);
    drive(4'b1011, 7'h79, 1'b1, 1);
    t0 = cyc + 1;
    drive(4'b1011, 7'h78, 1'b1, 8);
    idle(8);
    chk("t2_latency", 64'(rise_cyc - t0), 64'(11));
    check_outs("t2_frame", {16'h8765, 4'h0, 4'h0, 4'h0});
    chk("t2_loads", 64'(n_loads - l0), 64'(1));

    // Blank, error and dot
    scan({7'h30, 7'h24, 7'h7E, 7'h7F}, 4'b0111, 4'hF);
    idle(8);
    check_outs("t3_frame", {16'h3200, 4'b1000, 4'b0001, 4'b0010});

    // Backpressure across two frames
    out_ready = 1'b0;
    scan({7'h46, 7'h03, 7'h08, 7'h10}, 4'hF, 4'hF);
    idle(8);
    chk("t4_first_valid", 64'({out_valid, overrun}), 64'(2'b10));
    check_outs("t4_first", {16'hCBA9, 4'h0, 4'h0, 4'h0});
    scan({7'h40, 7'h0E, 7'h06, 7'h21}, 4'h0, 4'hF);
    idle(8);
    chk("t4_overrun", 64'({out_valid, overrun}), 64'(2'b11));
    check_outs("t4_held", {16'hCBA9, 4'h0, 4'h0, 4'h0});
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_release", 64'({out_valid, overrun}), 64'(2'b01));
    check_outs("t4_after", {16'hCBA9, 4'h0, 4'h0, 4'h0});

    // Strobe fault: two strobes low is idle
    l0 = n_loads;
    drive(4'b0011, 7'h79, 1'b1, 20);
    idle(10);
    chk("t5_no_valid", 64'(out_valid), 64'(0));

    // Three digits, then reset mid-scan
    scan({7'h00, 7'h30, 7'h24, 7'h79}, 4'hF, 4'b0111);
    idle(4);
    chk("t5_t6_no_frame", 64'(n_loads - l0), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_reset", 64'({out_valid, out_digits, out_dp,
        out_blank, out_err, overrun}), 64'(0));
    scan({7'h78, 7'h00, 7'h00, 7'h00}, 4'hF, 4'b1000);
    idle(8);
    chk("t6_partial", 64'({out_valid, 32'(n_loads - l0)}), 64'(0));
    scan({7'h78, 7'h02, 7'h12, 7'h19}, 4'hF, 4'hF);
    idle(8);
    check_outs("t6_frame", {16'h7654, 4'h0, 4'h0, 4'h0});
    chk("t6_loads", 64'(n_loads - l0), 64'(1));
    chk("all_frames_seen", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
